// File: rtl/count_check.sv
// Passive checker for a presettable up-counter: keeps a reference model of the
// count, stepped from the observed Q, and flags Q/TC disagreements.
module count_check #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MR,
  input  logic             Load,
  input  logic             Enable,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  input  logic             TC,
  output logic             synced,
  output logic [WIDTH-1:0] exp_q,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             first_valid,
  output logic [WIDTH-1:0] first_q,
  output logic [WIDTH-1:0] first_exp
);

  // state  | meaning
  // UNSYNC | model value unknown, nothing checked
  // SYNCED | model loaded by MR or Load, every edge is checked
  typedef enum logic {UNSYNC, SYNCED} state_e;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_val_q, exp_val_d;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             first_valid_q, first_valid_d;
  logic [WIDTH-1:0] first_q_q, first_q_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;

  logic [WIDTH-1:0] model_next;
  logic             tc_exp;
  logic             fault;

  always_comb begin
    if (MR)          model_next = '0;
    else if (Load)   model_next = P;
    else if (Enable) model_next = Q + WIDTH'(1);
    else             model_next = Q;
  end

  assign tc_exp = Enable & (Q == ALL_ONES);

  // Written as an if/else so an unknown Q or TC falls into the fault branch.
  always_comb begin
    fault = 1'b0;
    if (state_q == SYNCED) begin
      if ((Q == exp_val_q) && (TC == tc_exp)) fault = 1'b0;
      else                                    fault = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    exp_val_d     = exp_val_q;
    mismatch_d    = fault;
    err_count_d   = err_count_q;
    first_valid_d = first_valid_q;
    first_q_d     = first_q_q;
    first_exp_d   = first_exp_q;

    case (state_q)
      UNSYNC: begin
        if (MR || Load) begin
          state_d   = SYNCED;
          exp_val_d = model_next;
        end
      end
      SYNCED: begin
        exp_val_d = model_next;
      end
      default: state_d = UNSYNC;
    endcase

    if (fault) begin
      if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_W'(1);
      if (!first_valid_q) begin
        first_valid_d = 1'b1;
        first_q_d     = Q;
        first_exp_d   = exp_val_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= UNSYNC;
      exp_val_q     <= '0;
      mismatch_q    <= 1'b0;
      err_count_q   <= '0;
      first_valid_q <= 1'b0;
      first_q_q     <= '0;
      first_exp_q   <= '0;
    end else begin
      state_q       <= state_d;
      exp_val_q     <= exp_val_d;
      mismatch_q    <= mismatch_d;
      err_count_q   <= err_count_d;
      first_valid_q <= first_valid_d;
      first_q_q     <= first_q_d;
      first_exp_q   <= first_exp_d;
    end
  end

  assign synced      = (state_q == SYNCED);
  assign exp_q       = exp_val_q;
  assign mismatch    = mismatch_q;
  assign err_count   = err_count_q;
  assign first_valid = first_valid_q;
  assign first_q     = first_q_q;
  assign first_exp   = first_exp_q;

endmodule
